// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader for instruction memory (optional IMEM_LOADER_CHECKSUM_EN)
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t                  state;
    logic [7:0]              cnt_lo;
    logic [ADDR_WIDTH-1:0]   last_addr;
    logic [1:0]              byte_idx;
    logic [23:0]             word_buf;
    logic                    last_pend;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]              csum;
`endif

    logic                    accept;
    logic [15:0]             hdr_count;

    assign accept    = byte_valid && byte_ready;
    assign hdr_count = {byte_data, cnt_lo};

    // Loader FSM: header parse, little-endian word assembly, write strobes and status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt_lo     <= 8'd0;
            last_addr  <= '0;
            byte_idx   <= 2'd0;
            word_buf   <= 24'd0;
            last_pend  <= 1'b0;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
            cpu_hold   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= 8'd0;
`endif
        end else begin
            mem_we <= 1'b0;
            // Address advances in the cycle after each write strobe
            if (mem_we) begin
                mem_addr <= mem_addr + 1'b1;
            end
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state      <= S_HDR0;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        byte_idx   <= 2'd0;
                        mem_addr   <= '0;
                        last_pend  <= 1'b0;
                        cpu_hold   <= 1'b1;
                        busy       <= 1'b1;
                        byte_ready <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum       <= 8'd0;
`endif
                    end
                end
                S_HDR0: begin
                    if (accept) begin
                        cnt_lo <= byte_data;
                        state  <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (accept) begin
                        if (hdr_count == 16'd0) begin
                            state      <= S_DONE;
                            done       <= 1'b1;
                            cpu_hold   <= 1'b0;
                            busy       <= 1'b0;
                            byte_ready <= 1'b0;
                        end else if ({16'd0, hdr_count} > (32'd1 << ADDR_WIDTH)) begin
                            state      <= S_ERR;
                            error      <= 1'b1;
                            busy       <= 1'b0;
                            byte_ready <= 1'b0;
                        end else begin
                            // N-1 always fits in ADDR_WIDTH bits once N <= capacity
                            last_addr <= ADDR_WIDTH'(hdr_count - 16'd1);
                            state     <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (last_pend) begin
                        // Final word's strobe is out this cycle; wrap up the load
                        last_pend <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state      <= S_CSUM;
                        byte_ready <= 1'b1;
`else
                        state      <= S_DONE;
                        done       <= 1'b1;
                        cpu_hold   <= 1'b0;
                        busy       <= 1'b0;
`endif
                    end else if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum <= csum ^ byte_data;
`endif
                        if (byte_idx == 2'd3) begin
                            mem_wdata <= {byte_data, word_buf};
                            mem_we    <= 1'b1;
                            byte_idx  <= 2'd0;
                            if (mem_addr == last_addr) begin
                                last_pend  <= 1'b1;
                                byte_ready <= 1'b0;
                            end
                        end else begin
                            case (byte_idx)
                                2'd0:    word_buf[7:0]   <= byte_data;
                                2'd1:    word_buf[15:8]  <= byte_data;
                                default: word_buf[23:16] <= byte_data;
                            endcase
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (accept) begin
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                        if (byte_data == csum) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'd0;
    logic          byte_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          error;

    int tests = 0;
    int fails = 0;

    logic [AW-1:0] wa[$];
    logic [31:0]   wd[$];

    logic [7:0] basic [10] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h00, 8'h01, 8'h13, 8'h01, 8'hA0, 8'h02};

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Log every write strobe mid-cycle
    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 40) begin
            tick;
            n++;
        end
        chk("ready_wait", 32'(n < 40), 32'd1);
        tick;
        byte_valid = 1'b0;
    endtask

    task automatic run_basic(input bit gaps);
        wa.delete();
        wd.delete();
        pulse_start;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_ready", 32'(byte_ready), 32'd1);
        chk("start_hold", 32'(cpu_hold), 32'd1);
        chk("start_done_clr", 32'(done), 32'd0);
        for (int i = 0; i < 10; i++) begin
            if (gaps && i == 5) begin
                start = 1'b1;
                tick;
                start = 1'b0;
                chk("busy_start_ignored", 32'(busy), 32'd1);
            end else if (gaps) begin
                tick;
            end
            send(basic[i]);
            if (i == 5) begin
                chk("w0_we", 32'(mem_we), 32'd1);
                chk("w0_addr", 32'(mem_addr), 32'd0);
                chk("w0_data", mem_wdata, 32'h01000093);
                chk("w0_ready", 32'(byte_ready), 32'd1);
            end
        end
        chk("w1_we", 32'(mem_we), 32'd1);
        chk("w1_addr", 32'(mem_addr), 32'd1);
        chk("w1_data", mem_wdata, 32'h02A00113);
        chk("w1_ready_low", 32'(byte_ready), 32'd0);
        tick;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("csum_wait_done", 32'(done), 32'd0);
        chk("csum_ready", 32'(byte_ready), 32'd1);
        send(8'h22);
`endif
        chk("end_done", 32'(done), 32'd1);
        chk("end_hold", 32'(cpu_hold), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_ready", 32'(byte_ready), 32'd0);
        chk("end_error", 32'(error), 32'd0);
        chk("wr_count", 32'(wa.size()), 32'd2);
        chk("wr0_addr", 32'(wa[0]), 32'd0);
        chk("wr0_data", wd[0], 32'h01000093);
        chk("wr1_addr", 32'(wa[1]), 32'd1);
        chk("wr1_data", wd[1], 32'h02A00113);
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_ready"}, 32'(byte_ready), 32'd0);
        chk({pfx, "_we"}, 32'(mem_we), 32'd0);
        chk({pfx, "_addr"}, 32'(mem_addr), 32'd0);
        chk({pfx, "_wdata"}, mem_wdata, 32'd0);
        chk({pfx, "_hold"}, 32'(cpu_hold), 32'd1);
        chk({pfx, "_busy"}, 32'(busy), 32'd0);
        chk({pfx, "_done"}, 32'(done), 32'd0);
        chk({pfx, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        tick;
        tick;
        chk_reset_vals("rst");
        rst_n = 1'b1;
        tick;

        // Basic back-to-back load
        run_basic(1'b0);

        // Overflow: N = 257
        wa.delete();
        wd.delete();
        pulse_start;
        send(8'h01);
        send(8'h01);
        chk("ovf_error", 32'(error), 32'd1);
        chk("ovf_ready", 32'(byte_ready), 32'd0);
        chk("ovf_hold", 32'(cpu_hold), 32'd1);
        chk("ovf_busy", 32'(busy), 32'd0);
        chk("ovf_done", 32'(done), 32'd0);
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        repeat (5) tick;
        byte_valid = 1'b0;
        chk("ovf_ready_idle", 32'(byte_ready), 32'd0);
        chk("ovf_error_sticky", 32'(error), 32'd1);
        chk("ovf_no_write", 32'(wa.size()), 32'd0);

        // Zero count
        pulse_start;
        chk("zero_error_clr", 32'(error), 32'd0);
        send(8'h00);
        send(8'h00);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_hold", 32'(cpu_hold), 32'd0);
        chk("zero_busy", 32'(busy), 32'd0);
        tick;
        chk("zero_no_write", 32'(wa.size()), 32'd0);

        // Stream gaps plus a start pulse mid-load
        run_basic(1'b1);

        // Reset mid-load
        wa.delete();
        wd.delete();
        pulse_start;
        for (int i = 0; i < 6; i++) send(basic[i]);
        chk("mid_w0_we", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        tick;
        chk_reset_vals("midrst");
        rst_n = 1'b1;
        repeat (4) tick;
        chk("midrst_writes", 32'(wa.size()), 32'd1);
        chk("midrst_idle_busy", 32'(busy), 32'd0);
        run_basic(1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum match
        wa.delete();
        wd.delete();
        pulse_start;
        send(8'h01); send(8'h00); send(8'h93); send(8'h00); send(8'h00); send(8'h01);
        tick;
        send(8'h92);
        chk("cs_ok_done", 32'(done), 32'd1);
        chk("cs_ok_hold", 32'(cpu_hold), 32'd0);

        // Checksum mismatch
        wa.delete();
        wd.delete();
        pulse_start;
        send(8'h01); send(8'h00); send(8'h93); send(8'h00); send(8'h00); send(8'h01);
        tick;
        send(8'h00);
        chk("cs_bad_error", 32'(error), 32'd1);
        chk("cs_bad_hold", 32'(cpu_hold), 32'd1);
        chk("cs_bad_done", 32'(done), 32'd0);
        chk("cs_bad_writes", 32'(wa.size()), 32'd1);
        chk("cs_bad_wr_addr", 32'(wa[0]), 32'd0);
        chk("cs_bad_wr_data", wd[0], 32'h01000093);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory. It accepts a byte stream over a valid/ready handshake, parses a 2-byte word-count header, and assembles little-endian 32-bit instruction words. Each word goes out on the memory write port at consecutive word addresses. The core is held in reset (`cpu_hold`) until the load completes, so the fetch stage only sees a fully written program.

## Interface
- `ADDR_WIDTH`, default 8: word-address width; capacity is 2^ADDR_WIDTH words (256 words = 1 KB).
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle request to begin a load; ignored while `busy`.
- `byte_valid` in 1: the stream byte is valid.
- `byte_data` in 8: stream byte.
- `byte_ready` out 1: the loader accepts a byte this cycle. A byte transfers when `byte_valid && byte_ready`.
- `mem_we` out 1: one-cycle write strobe to instruction memory.
- `mem_addr` out ADDR_WIDTH: word index (byte address = `mem_addr`<<2).
- `mem_wdata` out 32: assembled instruction word.
- `cpu_hold` out 1: keeps the core in reset; high until a load completes.
- `busy` out 1: a load is in progress.
- `done` out 1: the last load succeeded; sticky until the next `start`.
- `error` out 1: the last load failed; sticky until the next `start`.

## Operation
- States are IDLE, HDR0, HDR1, DATA, CSUM (only with the macro), DONE, ERR.
- IDLE, DONE and ERR go to HDR0 on `start`. Entering HDR0 clears `done`, `error`, the byte counter, `mem_addr` and the checksum, and raises `cpu_hold`.
- HDR0 accepts the count low byte, then goes to HDR1.
- HDR1 accepts the count high byte. The 16-bit count N is then checked:
  - N == 0: go to DONE.
  - N > 2^ADDR_WIDTH: go to ERR.
  - Otherwise: go to DATA.
- DATA collects bytes little-endian. Byte k of a word fills bits [8k+7:8k].
  - On the 4th byte: register `mem_wdata`, then pulse `mem_we` for the following cycle at the current `mem_addr`.
  - `mem_addr` increments after that write.
  - After word N-1 is written, go to DONE (or to CSUM with the macro).
- DONE: `done`=1, `cpu_hold`=0, `busy`=0.
- ERR: `error`=1, `cpu_hold` stays 1, `busy`=0, and no further writes occur.
- `byte_ready` = 1 exactly in HDR0, HDR1, DATA and CSUM. Exception: it is 0 in the `mem_we` cycle after the final word.
- Bytes presented outside those states are not consumed.
- `start` while `busy` is ignored, with no effect on the state or the counters.

## Timing
- Reset values: `byte_ready` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `cpu_hold` 1, `busy` 0, `done` 0, `error` 0; state is IDLE.
- `start` seen in cycle t gives `busy`=1 and `byte_ready`=1 in cycle t+1.
- The 4th byte of a word accepted in cycle t gives `mem_we`=1 with valid `mem_addr`/`mem_wdata` in cycle t+1. The next byte may be accepted in that same cycle t+1, except after the final word.
- The final word's `mem_we` in cycle t gives `done`=1 and `cpu_hold`=0 in cycle t+1.
- N==0: second header byte accepted in cycle t gives `done` in cycle t+1.
- Overflow: `error` in cycle t+1.
- Gaps in `byte_valid` stall progress with no side effects. Partial word bytes are retained.
- `rst_n`=0 mid-load returns everything to reset values on the next edge. The partial word is discarded and no write is issued.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - After the last data word, the loader enters CSUM and accepts one more byte.
  - That byte must equal the XOR of all payload bytes (header excluded).
  - Match gives DONE; mismatch gives ERR with `cpu_hold` held at 1.
  - The words are already written either way.
- Not defined: no CSUM state; DONE follows the last write directly.

## Test plan
- Basic load:
  - Start, then bytes 02 00 93 00 00 01 13 01 A0 02.
  - Expect `mem_we` at addr 0 with 0x01000093, then `mem_we` at addr 1 with 0x02A00113.
  - Expect `done`=1 and `cpu_hold`=0 one cycle after the second write.
- Overflow:
  - ADDR_WIDTH=8, header 01 01 (N=257).
  - Expect `error`=1, `byte_ready`=0, no `mem_we` ever, `cpu_hold`=1.
- Zero count:
  - Header 00 00.
  - Expect `done` one cycle after the second byte and no `mem_we`.
- Stream gaps:
  - Basic load with `byte_valid` low on alternate cycles, plus a `start` pulse mid-load.
  - Expect the same writes and the same final state.
- Reset mid-load:
  - Assert `rst_n`=0 after 6 bytes of the basic load.
  - Expect all outputs at reset values and no write of the second word.
  - A fresh `start` plus the full stream then succeeds.
- Checksum (macro on):
  - Bytes 01 00 93 00 00 01 then checksum 92: expect `done`.
  - Same stream with checksum 00: expect `error`, `cpu_hold`=1, and the addr-0 write of 0x01000093 still performed.
